data_memory_bank: RTL and testbench
===================================

// Module: data_memory_bank
// PURPOSE
//  Parametrised MEM-stage data memory: byte/half/word loads and stores, sign/zero extension, misalignment detection.
//  Also contains a debug dump engine that streams every word to the debug unit over a valid/ready handshake.
//  Sits between EX/MEM and MEM/WB pipeline registers; dump port feeds the UART debug unit.
// PARAMETERS
//  DATA_W  32  word width in bits; must be 32 (byte/half lanes assume 4 bytes per word)
//  DEPTH   32  number of words; power of 2, >= 2
//  ADDR_W  32  width of the byte address input
//  IDX_W = clog2(DEPTH); derived locally, not overridable
// PORTS
//  clk          in   1       clock; all state updates on falling edge
//  rst          in   1       asynchronous, active-high reset
//  mem_read     in   1       load request this cycle
//  mem_write    in   1       store request this cycle
//  size         in   2       00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  load_unsigned in  1       1: zero-extend byte/half loads; 0: sign-extend
//  addr         in   ADDR_W  byte address
//  wdata        in   DATA_W  store data; byte/half taken from LSBs
//  rdata        out  DATA_W  registered load result
//  misalign     out  1       registered; access this edge was misaligned
//  range_err    out  1       registered; address outside DEPTH (DMEM_RANGE_CHECK_EN only, else 0)
//  dbg_start    in   1       begin full-memory dump
//  dbg_ready    in   1       debug consumer accepts dbg_data
//  dbg_valid    out  1       dbg_data/dbg_idx are valid
//  dbg_idx      out  IDX_W   word index being presented
//  dbg_data     out  DATA_W  word contents at dbg_idx
//  dbg_busy     out  1       dump in progress
//  dbg_done     out  1       one-cycle pulse after last word accepted
// BEHAVIOUR
//  - Reset (async): all DEPTH words = 0; rdata=0, misalign=0, range_err=0; FSM=IDLE; dbg_* outputs = 0. No Z outputs.
//  - Addressing: word index = addr[IDX_W+1:2], lane = addr[1:0]; little-endian (lane 0 = bits 7:0).
//  - Alignment: half needs addr[0]=0; word needs addr[1:0]=0. On misaligned access: store suppressed, load gives rdata=0,
//    misalign=1 for that edge. misalign returns to 0 on the next edge without a misaligned access.
//  - Store: byte writes lane addr[1:0]; half writes lanes {addr[1],0},{addr[1],1}; word writes all lanes; other lanes kept.
//  - Load: rdata updated on the same falling edge (half-cycle latency, ready for MEM/WB capture); byte/half sign- or
//    zero-extended by load_unsigned. rdata holds its value when mem_read=0.
//  - mem_read & mem_write together: store performed; rdata returns pre-write contents (read-before-write).
//  - FSM IDLE: dbg_start=1 -> DUMP with idx=0. dbg_start is ignored outside IDLE.
//  - FSM DUMP: dbg_busy=1, dbg_valid=1, dbg_data=mem[idx]. Edge with dbg_ready=1 -> idx+1.
//    Acceptance at idx=DEPTH-1 -> DONE. dbg_valid and dbg_data stay stable while dbg_ready=0.
//  - FSM DONE: dbg_done=1 for one cycle, dbg_valid=0 -> IDLE. dbg_idx returns to 0.
//  - While dbg_busy: mem_write suppressed (CPU halted); loads still serviced.
//  - Reset mid-dump: immediate IDLE, memory cleared, no dbg_done pulse.
// CONFIGURATION
//  DMEM_RANGE_CHECK_EN defined:
//    addr[ADDR_W-1:IDX_W+2] != 0 -> store suppressed, rdata=0, range_err=1 that edge.
//    Misalignment is checked independently; both flags may assert together.
//  DMEM_RANGE_CHECK_EN undefined:
//    upper address bits ignored (index wraps modulo DEPTH); range_err tied 0.
// TESTING
//  1 reset -> every word reads 0 via word loads at addr 0..4*(DEPTH-1); rdata=0, dbg_valid=0.
//  2 word store 0x8899AABB @0x10; byte store 0x7F @0x11; half store 0xF00D @0x12
//    -> word load @0x10 = 0xF00D7FBB; lbu @0x10 = 0x000000BB; lb @0x10 = 0xFFFFFFBB; lh @0x12 = 0xFFFFF00D.
//  3 half load @0x13 and word store @0x06 -> misalign=1, rdata=0, word @0x04 unchanged.
//  4 load+store same edge @0x20 (old 5, new 9) -> rdata=5; next load = 9.
//  5 dbg_start with word i = i+1; dbg_ready toggled 1,0,1...
//    -> DEPTH words in order 1..DEPTH, held stable while ready=0; dbg_done single pulse.
//    A store issued during the dump is ignored.
//  6 DMEM_RANGE_CHECK_EN, DEPTH=32: store @0x80 -> range_err=1, word 0 unchanged.
//    Without the macro: the same store writes word 0.

Source files
------------

// File: rtl/data_memory_bank_if.sv
// Bus bundle for data_memory_bank: CPU load/store port plus the debug dump stream.
// master = pipeline/debug side, slave = the memory bank.
interface data_memory_bank_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 32
);
   localparam int IDX_W = $clog2(DEPTH);

   logic              mem_read;
   logic              mem_write;
   logic [1:0]        size;
   logic              load_unsigned;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              misalign;
   logic              range_err;
   logic              dbg_start;
   logic              dbg_ready;
   logic              dbg_valid;
   logic [IDX_W-1:0]  dbg_idx;
   logic [DATA_W-1:0] dbg_data;
   logic              dbg_busy;
   logic              dbg_done;

   modport master (
      output mem_read, mem_write, size, load_unsigned, addr, wdata, dbg_start, dbg_ready,
      input  rdata, misalign, range_err, dbg_valid, dbg_idx, dbg_data, dbg_busy, dbg_done
   );

   modport slave (
      input  mem_read, mem_write, size, load_unsigned, addr, wdata, dbg_start, dbg_ready,
      output rdata, misalign, range_err, dbg_valid, dbg_idx, dbg_data, dbg_busy, dbg_done
   );
endinterface

// File: rtl/data_memory_bank.sv
// MEM-stage data memory with byte/half/word access, extension, misalignment flagging and a debug dump engine.
// Optional address range checking is enabled by defining DMEM_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for dbg_start
// DUMP  | presenting mem[dbg_idx] on the debug stream
// DONE  | one-cycle dbg_done pulse, then back to IDLE
module data_memory_bank #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 32
) (
   input logic                clk,
   input logic                rst,
   data_memory_bank_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic              misalign_q;
   logic              range_err_q;
   logic              dbg_valid_q;
   logic              dbg_busy_q;
   logic              dbg_done_q;
   logic [IDX_W-1:0]  dbg_idx_q;
   logic [DATA_W-1:0] dbg_data_q;

   logic [IDX_W-1:0]  widx;
   logic [1:0]        lane;
   logic [DATA_W-1:0] cur_word;
   logic [DATA_W-1:0] wr_word;
   logic [DATA_W-1:0] load_val;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic              misaligned;
   logic              out_of_range;
   logic              access;
   logic              do_store;
   logic [IDX_W-1:0]  idx_nxt;

   assign widx     = bus.addr[IDX_W+1:2];
   assign lane     = bus.addr[1:0];
   assign cur_word = mem[widx];
   assign byte_sel = cur_word[{lane, 3'b000} +: 8];
   assign half_sel = cur_word[{lane[1], 4'b0000} +: 16];
   assign access   = bus.mem_read | bus.mem_write;
   assign idx_nxt  = dbg_idx_q + IDX_W'(1);

`ifdef DMEM_RANGE_CHECK_EN
   assign out_of_range = |bus.addr[ADDR_W-1:IDX_W+2];
`else
   // Upper address bits are deliberately ignored; the index wraps modulo DEPTH.
   logic unused_upper_addr;
   assign unused_upper_addr = ^bus.addr[ADDR_W-1:IDX_W+2];
   assign out_of_range      = 1'b0;
`endif

   always_comb begin
      case (bus.size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = bus.addr[0];
         default: misaligned = |bus.addr[1:0];
      endcase
   end

   always_comb begin
      case (bus.size)
         2'b00:   load_val = bus.load_unsigned ? {{(DATA_W-8){1'b0}}, byte_sel}
                                               : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         2'b01:   load_val = bus.load_unsigned ? {{(DATA_W-16){1'b0}}, half_sel}
                                               : {{(DATA_W-16){half_sel[15]}}, half_sel};
         default: load_val = cur_word;
      endcase
   end

   always_comb begin
      wr_word = cur_word;
      case (bus.size)
         2'b00:   wr_word[{lane, 3'b000} +: 8]      = bus.wdata[7:0];
         2'b01:   wr_word[{lane[1], 4'b0000} +: 16] = bus.wdata[15:0];
         default: wr_word = bus.wdata;
      endcase
   end

   // CPU is halted during a dump, so stores are dropped while busy.
   assign do_store = bus.mem_write & ~misaligned & ~out_of_range & ~dbg_busy_q;

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_store) begin
         mem[widx] <= wr_word;
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         rdata_q     <= '0;
         misalign_q  <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         if (bus.mem_read) rdata_q <= (misaligned | out_of_range) ? '0 : load_val;
         misalign_q  <= access & misaligned;
         range_err_q <= access & out_of_range;
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         dbg_valid_q <= 1'b0;
         dbg_busy_q  <= 1'b0;
         dbg_done_q  <= 1'b0;
         dbg_idx_q   <= '0;
         dbg_data_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               dbg_done_q <= 1'b0;
               if (bus.dbg_start) begin
                  state       <= DUMP;
                  dbg_valid_q <= 1'b1;
                  dbg_busy_q  <= 1'b1;
                  dbg_idx_q   <= '0;
                  dbg_data_q  <= mem[0];
               end
            end
            DUMP: begin
               if (bus.dbg_ready) begin
                  if (dbg_idx_q == LAST_IDX) begin
                     state       <= DONE;
                     dbg_valid_q <= 1'b0;
                     dbg_busy_q  <= 1'b0;
                     dbg_done_q  <= 1'b1;
                     dbg_idx_q   <= '0;
                     dbg_data_q  <= '0;
                  end else begin
                     dbg_idx_q  <= idx_nxt;
                     dbg_data_q <= mem[idx_nxt];
                  end
               end
            end
            DONE: begin
               dbg_done_q <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.misalign  = misalign_q;
   assign bus.range_err = range_err_q;
   assign bus.dbg_valid = dbg_valid_q;
   assign bus.dbg_busy  = dbg_busy_q;
   assign bus.dbg_done  = dbg_done_q;
   assign bus.dbg_idx   = dbg_idx_q;
   assign bus.dbg_data  = dbg_data_q;
endmodule

// File: tb/tb_data_memory_bank.sv
// Self-checking bench for data_memory_bank: directed cases plus random loads/stores against an array model.
module tb_data_memory_bank;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 32;
   localparam int IDX_W  = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] exp_rdata;

   data_memory_bank_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

   data_memory_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] m_extract(logic [31:0] word, int a, int sz, bit uns);
      logic [31:0] v;
      int sh;
      sh = 8 * (a % 4);
      if (sz == 0) begin
         v = (word >> sh) & 32'hFF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 1) begin
         v = (word >> sh) & 32'hFFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_merge(logic [31:0] word, int a, int sz, logic [31:0] wd);
      logic [31:0] mask;
      int sh;
      sh = 8 * (a % 4);
      if (sz == 0)      mask = 32'hFF << sh;
      else if (sz == 1) mask = 32'hFFFF << sh;
      else begin
         mask = 32'hFFFF_FFFF;
         sh   = 0;
      end
      return (word & ~mask) | ((wd << sh) & mask);
   endfunction

   function automatic bit m_misaligned(int a, int sz);
      if (sz == 0) return 1'b0;
      if (sz == 1) return (a % 2) != 0;
      return (a % 4) != 0;
   endfunction

   function automatic bit m_out_of_range(logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
      return a >= 32'(4 * DEPTH);
`else
      return 1'b0;
`endif
   endfunction

   task automatic drive(bit rd, bit wr, int sz, bit uns, logic [31:0] a, logic [31:0] wd);
      bus.mem_read      = rd;
      bus.mem_write     = wr;
      bus.size          = 2'(sz);
      bus.load_unsigned = uns;
      bus.addr          = a;
      bus.wdata         = wd;
   endtask

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic idle_bus;
      drive(0, 0, 2, 0, 0, 0);
   endtask

   task automatic test_reset;
      bus.dbg_start = 0;
      bus.dbg_ready = 0;
      idle_bus();
      rst = 1;
      #12;
      n_chk++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
      n_chk++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", bus.misalign); end
      n_chk++; if (bus.range_err !== 1'b0) begin n_fail++; $display("FAIL reset_range_err got=%b exp=0", bus.range_err); end
      n_chk++; if (bus.dbg_valid !== 1'b0 || bus.dbg_busy !== 1'b0 || bus.dbg_done !== 1'b0)
         begin n_fail++; $display("FAIL reset_dbg got v=%b b=%b d=%b exp 0", bus.dbg_valid, bus.dbg_busy, bus.dbg_done); end
      rst = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
      exp_rdata = 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 0, 2, 0, 32'(4 * i), 0);
         step();
         n_chk++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_word[%0d] got=%h exp=0", i, bus.rdata); end
      end
      idle_bus();
   endtask

   task automatic test_lanes;
      drive(0, 1, 2, 0, 32'h10, 32'h8899AABB); step();
      drive(0, 1, 0, 0, 32'h11, 32'h0000007F); step();
      drive(0, 1, 1, 0, 32'h12, 32'h0000F00D); step();
      model_mem[4] = 32'hF00D7FBB;
      drive(1, 0, 2, 0, 32'h10, 0); step();
      n_chk++; if (bus.rdata !== 32'hF00D7FBB) begin n_fail++; $display("FAIL lw_0x10 got=%h exp=F00D7FBB", bus.rdata); end
      drive(1, 0, 0, 1, 32'h10, 0); step();
      n_chk++; if (bus.rdata !== 32'h000000BB) begin n_fail++; $display("FAIL lbu_0x10 got=%h exp=000000BB", bus.rdata); end
      drive(1, 0, 0, 0, 32'h10, 0); step();
      n_chk++; if (bus.rdata !== 32'hFFFFFFBB) begin n_fail++; $display("FAIL lb_0x10 got=%h exp=FFFFFFBB", bus.rdata); end
      drive(1, 0, 1, 0, 32'h12, 0); step();
      n_chk++; if (bus.rdata !== 32'hFFFFF00D) begin n_fail++; $display("FAIL lh_0x12 got=%h exp=FFFFF00D", bus.rdata); end
      idle_bus(); step();
      n_chk++; if (bus.rdata !== 32'hFFFFF00D) begin n_fail++; $display("FAIL rdata_hold got=%h exp=FFFFF00D", bus.rdata); end
      exp_rdata = 32'hFFFFF00D;
   endtask

   task automatic test_misalign;
      drive(0, 1, 2, 0, 32'h04, 32'h12345678); step();
      model_mem[1] = 32'h12345678;
      drive(1, 0, 1, 0, 32'h13, 0); step();
      n_chk++; if (bus.misalign !== 1'b1) begin n_fail++; $display("FAIL mis_lh_flag got=%b exp=1", bus.misalign); end
      n_chk++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL mis_lh_rdata got=%h exp=0", bus.rdata); end
      drive(0, 1, 2, 0, 32'h06, 32'hDEADBEEF); step();
      n_chk++; if (bus.misalign !== 1'b1) begin n_fail++; $display("FAIL mis_sw_flag got=%b exp=1", bus.misalign); end
      drive(1, 0, 2, 0, 32'h04, 0); step();
      n_chk++; if (bus.rdata !== 32'h12345678) begin n_fail++; $display("FAIL mis_word_kept got=%h exp=12345678", bus.rdata); end
      n_chk++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL mis_clear got=%b exp=0", bus.misalign); end
      exp_rdata = 32'h12345678;
      idle_bus();
   endtask

   task automatic test_read_before_write;
      drive(0, 1, 2, 0, 32'h20, 32'd5); step();
      drive(1, 1, 2, 0, 32'h20, 32'd9); step();
      n_chk++; if (bus.rdata !== 32'd5) begin n_fail++; $display("FAIL rbw_old got=%h exp=5", bus.rdata); end
      drive(1, 0, 2, 0, 32'h20, 0); step();
      n_chk++; if (bus.rdata !== 32'd9) begin n_fail++; $display("FAIL rbw_new got=%h exp=9", bus.rdata); end
      model_mem[8] = 32'd9;
      exp_rdata = 32'd9;
      idle_bus();
   endtask

   task automatic test_random;
      for (int n = 0; n < 300; n++) begin
         bit          rd, wr, uns, mis, oor;
         int          sz, idx;
         logic [31:0] a, wd, old;
         rd  = 1'($urandom_range(0, 1));
         wr  = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         sz  = $urandom_range(0, 3);
         a   = 32'($urandom_range(0, 4 * DEPTH - 1));
         if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << (IDX_W + 2));
         wd  = $urandom;
         mis = m_misaligned(int'(a % 4), sz);
         oor = m_out_of_range(a);
         idx = int'((a / 4) % DEPTH);
         old = model_mem[idx];
         if (rd) exp_rdata = (mis || oor) ? 32'h0 : m_extract(old, int'(a % 4), sz, uns);
         if (wr && !mis && !oor) model_mem[idx] = m_merge(old, int'(a % 4), sz, wd);
         drive(rd, wr, sz, uns, a, wd);
         step();
         n_chk++; if (bus.rdata !== exp_rdata)
            begin n_fail++; $display("FAIL rand_rdata[%0d] a=%h sz=%0d got=%h exp=%h", n, a, sz, bus.rdata, exp_rdata); end
         n_chk++; if (bus.misalign !== ((rd || wr) && mis))
            begin n_fail++; $display("FAIL rand_misalign[%0d] got=%b exp=%b", n, bus.misalign, (rd || wr) && mis); end
         n_chk++; if (bus.range_err !== ((rd || wr) && oor))
            begin n_fail++; $display("FAIL rand_range_err[%0d] got=%b exp=%b", n, bus.range_err, (rd || wr) && oor); end
      end
      idle_bus();
   endtask

   task automatic test_dump;
      int exp_i;
      int done_cnt;
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 1, 2, 0, 32'(4 * i), 32'(i + 1));
         step();
         model_mem[i] = 32'(i + 1);
      end
      idle_bus();
      bus.dbg_start = 1;
      step();
      bus.dbg_start = 0;
      exp_i    = 0;
      done_cnt = 0;
      for (int cyc = 0; cyc < 400 && exp_i < DEPTH; cyc++) begin
         bit rdy;
         rdy = (cyc % 2) == 0;
         n_chk++; if (bus.dbg_valid !== 1'b1 || bus.dbg_busy !== 1'b1)
            begin n_fail++; $display("FAIL dump_valid cyc=%0d got v=%b b=%b exp 1", cyc, bus.dbg_valid, bus.dbg_busy); end
         n_chk++; if (bus.dbg_idx !== IDX_W'(exp_i) || bus.dbg_data !== model_mem[exp_i])
            begin n_fail++; $display("FAIL dump_word cyc=%0d got idx=%0d data=%h exp idx=%0d data=%h",
                                     cyc, bus.dbg_idx, bus.dbg_data, exp_i, model_mem[exp_i]); end
         if (bus.dbg_done) done_cnt++;
         if (cyc == 3) drive(0, 1, 2, 0, 32'h0, 32'hDEADBEEF);
         else          idle_bus();
         bus.dbg_ready = rdy;
         step();
         if (rdy) exp_i++;
      end
      bus.dbg_ready = 0;
      idle_bus();
      n_chk++; if (exp_i != DEPTH) begin n_fail++; $display("FAIL dump_timeout got=%0d words exp=%0d", exp_i, DEPTH); end
      n_chk++; if (bus.dbg_done !== 1'b1 || bus.dbg_valid !== 1'b0 || bus.dbg_idx !== '0)
         begin n_fail++; $display("FAIL dump_done got d=%b v=%b idx=%0d exp d=1 v=0 idx=0", bus.dbg_done, bus.dbg_valid, bus.dbg_idx); end
      step();
      n_chk++; if (bus.dbg_done !== 1'b0 || done_cnt != 0)
         begin n_fail++; $display("FAIL dump_pulse got d=%b early=%0d exp d=0 early=0", bus.dbg_done, done_cnt); end
      drive(1, 0, 2, 0, 32'h0, 0); step();
      n_chk++; if (bus.rdata !== model_mem[0]) begin n_fail++; $display("FAIL dump_store_ignored got=%h exp=%h", bus.rdata, model_mem[0]); end
      exp_rdata = model_mem[0];
      idle_bus();
   endtask

   task automatic test_range;
      logic [31:0] exp_w0;
      drive(1, 1, 2, 0, 32'h80, 32'hCAFE0001); step();
`ifdef DMEM_RANGE_CHECK_EN
      exp_w0 = model_mem[0];
      n_chk++; if (bus.range_err !== 1'b1) begin n_fail++; $display("FAIL range_flag got=%b exp=1", bus.range_err); end
      n_chk++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL range_rdata got=%h exp=0", bus.rdata); end
`else
      exp_w0 = 32'hCAFE0001;
      n_chk++; if (bus.range_err !== 1'b0) begin n_fail++; $display("FAIL range_flag got=%b exp=0", bus.range_err); end
      n_chk++; if (bus.rdata !== model_mem[0]) begin n_fail++; $display("FAIL range_wrap_rbw got=%h exp=%h", bus.rdata, model_mem[0]); end
`endif
      model_mem[0] = exp_w0;
      drive(1, 0, 2, 0, 32'h0, 0); step();
      n_chk++; if (bus.rdata !== exp_w0) begin n_fail++; $display("FAIL range_word0 got=%h exp=%h", bus.rdata, exp_w0); end
      n_chk++; if (bus.range_err !== 1'b0) begin n_fail++; $display("FAIL range_clear got=%b exp=0", bus.range_err); end
      idle_bus();
   endtask

   task automatic test_reset_mid_dump;
      int done_seen;
      bus.dbg_start = 1; step(); bus.dbg_start = 0;
      bus.dbg_ready = 1; step(); step(); bus.dbg_ready = 0;
      #2 rst = 1;
      #1;
      n_chk++; if (bus.dbg_busy !== 1'b0 || bus.dbg_valid !== 1'b0 || bus.dbg_idx !== '0)
         begin n_fail++; $display("FAIL midrst_dbg got b=%b v=%b idx=%0d exp 0", bus.dbg_busy, bus.dbg_valid, bus.dbg_idx); end
      #2 rst = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
      done_seen = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.dbg_done) done_seen++;
      end
      n_chk++; if (done_seen != 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d pulses exp=0", done_seen); end
      drive(1, 0, 2, 0, 32'h14, 0); step();
      n_chk++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_mem_cleared got=%h exp=0", bus.rdata); end
      idle_bus();
   endtask

   initial begin
      test_reset();
      test_lanes();
      test_misalign();
      test_read_before_write();
      test_random();
      test_dump();
      test_range();
      test_reset_mid_dump();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
